// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Two-client round-robin arbiter and sequencer in front of one shared WIDTH-bit
// divider. In IDLE it picks a requester (on a tie, the client not served last),
// latches that client's operands into div_x/div_y and sends go. It then waits
// for done, captures quotient/remainder/error and returns them with a one-cycle
// valid strobe to the winning client. Before returning to IDLE it waits for
// done to fall, so a done level held over from one operation cannot complete
// the next one.
//
// Optional feature macro: DIV_ARB_TIMEOUT_EN
//   Defined   : a WAIT watchdog. After TIMEOUT cycles in WAIT with no done,
//               the operation completes with err=1, q=r=0, and div_rst pulses
//               for the single RESP cycle to abort the divider.
//   Undefined : WAIT waits forever and div_rst is simply rst.
//
// Parameters
//   WIDTH    operand/result width
//   TIMEOUT  watchdog limit in cycles (2..255), used only with the macro
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   req0/req1            level requests, held until the matching ack
//   x0,y0 / x1,y1        client operands (dividend, divisor)
//   ack0/ack1            one-cycle pulse: request taken, operands latched
//   valid0/valid1        one-cycle pulse: q/r/err belong to this client
//   q, r, err            registered results, held until the next capture
//   busy                 high in every state except IDLE
//   cs                   state code IDLE=0 GO=1 WAIT=2 RESP=3 RELEASE=4
//   div_go, div_x/div_y  registered go and operands to the divider
//   div_rst              rst OR watchdog abort (combinational)
//   div_done/div_error   divider status; done may be a pulse or a level
//   div_q/div_r          divider results, valid while div_done=1
// -----------------------------------------------------------------------------
module div_arbiter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] y1,
   output logic             ack0,
   output logic             ack1,
   output logic             valid0,
   output logic             valid1,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             err,
   output logic             busy,
   output logic [2:0]       cs,
   output logic             div_go,
   output logic [WIDTH-1:0] div_x,
   output logic [WIDTH-1:0] div_y,
   output logic             div_rst,
   input  logic             div_done,
   input  logic             div_error,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r
);

   // The watchdog counter is 8 bits wide, which bounds the legal limit.
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
      $error("div_arbiter: TIMEOUT must be in 2..255");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GO      = 3'd1,
      S_WAIT    = 3'd2,
      S_RESP    = 3'd3,
      S_RELEASE = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             grant_q, grant_d;   // client currently being served
   logic             last_q,  last_d;    // client served most recently
   logic [WIDTH-1:0] div_x_q, div_x_d;
   logic [WIDTH-1:0] div_y_q, div_y_d;
   logic [WIDTH-1:0] q_q,     q_d;
   logic [WIDTH-1:0] r_q,     r_d;
   logic             err_q,   err_d;
   logic             ack0_q,  ack0_d;
   logic             ack1_q,  ack1_d;
   logic             valid0_q, valid0_d;
   logic             valid1_q, valid1_d;
   logic             div_go_q, div_go_d;
   logic             busy_q,  busy_d;

`ifdef DIV_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q,   cnt_d;
   logic       abort_q, abort_d;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      div_x_d = div_x_q;
      div_y_d = div_y_q;
      q_d     = q_q;
      r_d     = r_q;
      err_d   = err_q;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      abort_d = 1'b0;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // On a tie the pointer hands the grant to the other client.
               if (req0 && req1) grant_d = ~last_q;
               else              grant_d = req1;
               div_x_d = grant_d ? x1 : x0;
               div_y_d = grant_d ? y1 : y0;
               state_d = S_GO;
            end
         end

         S_GO: begin
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = S_WAIT;
         end

         S_WAIT: begin
            // A done arriving on the watchdog's last cycle takes priority.
            if (div_done) begin
               q_d     = div_q;
               r_d     = div_r;
               err_d   = div_error;
               state_d = S_RESP;
            end
`ifdef DIV_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LIMIT) begin
               q_d     = '0;
               r_d     = '0;
               err_d   = 1'b1;
               abort_d = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end

         S_RESP: begin
            last_d  = grant_q;
            state_d = S_RELEASE;
         end

         S_RELEASE: begin
            if (!div_done) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Strobes are registered: decode them from the state being entered.
      ack0_d   = (state_d == S_GO)   && !grant_d;
      ack1_d   = (state_d == S_GO)   &&  grant_d;
      div_go_d = (state_d == S_GO);
      valid0_d = (state_d == S_RESP) && !grant_d;
      valid1_d = (state_d == S_RESP) &&  grant_d;
      busy_d   = (state_d != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register samples the values
      // present before this edge regardless of statement order.
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;   // client 0 wins the first tie
         div_x_q  <= '0;
         div_y_q  <= '0;
         q_q      <= '0;
         r_q      <= '0;
         err_q    <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         div_go_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         div_x_q  <= div_x_d;
         div_y_q  <= div_y_d;
         q_q      <= q_d;
         r_q      <= r_d;
         err_q    <= err_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         div_go_q <= div_go_d;
         busy_q   <= busy_d;
      end
   end

`ifdef DIV_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   // abort_q is high only during the RESP cycle that follows a watchdog expiry.
   assign div_rst = rst | abort_q;
`else
   assign div_rst = rst;
`endif

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign valid0 = valid0_q;
   assign valid1 = valid1_q;
   assign q      = q_q;
   assign r      = r_q;
   assign err    = err_q;
   assign busy   = busy_q;
   assign cs     = state_q;
   assign div_go = div_go_q;
   assign div_x  = div_x_q;
   assign div_y  = div_y_q;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Two-requester round-robin arbiter and sequencer for the shared WIDTH-bit divider unit (go/done/error handshake, operands x/y, results r/q). Accepts requests from two independent clients, loads the winner's operands into the divider, pulses go, waits for done, and returns quotient, remainder and error to the winning client with a one-cycle valid strobe. Sits between client logic and a single divider instance in the top level.

## Interface
- WIDTH, 4: operand/result width.
- TIMEOUT, 64: watchdog limit in cycles, legal range 2..255. Used only with DIV_ARB_TIMEOUT_EN.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0, req1  in  1  level request from client 0 or 1; held until matching ack.
- x0, y0, x1, y1  in  WIDTH  client operands (dividend x, divisor y); stable while req is high.
- ack0, ack1  out  1  one-cycle pulse: request taken, operands latched.
- valid0, valid1  out  1  one-cycle pulse: result on q/r/err belongs to this client.
- q, r  out  WIDTH  registered quotient and remainder.
- err  out  1  registered error: divider error, or timeout.
- busy  out  1  high in every state except IDLE.
- cs  out  3  current state code: IDLE=0, GO=1, WAIT=2, RESP=3, RELEASE=4.
- div_go  out  1  go to divider.
- div_x, div_y  out  WIDTH  registered operands to divider.
- div_rst  out  1  divider reset: rst OR timeout abort pulse.
- div_done, div_error  in  1  divider status. div_done may be a pulse or held level.
- div_q, div_r  in  WIDTH  divider results, valid while div_done=1.

## Operation
- IDLE: if req0 or req1 is high, select the winner. With both high, grant the client not served last. The last-grant pointer resets to 1, so client 0 wins the first tie. Latch winner's x/y into div_x/div_y, record grant id, go to GO. With no request, stay.
- GO (1 cycle): div_go=1 and ack of granted client=1. Go to WAIT.
- WAIT: on first cycle with div_done=1, capture div_q/div_r/div_error into q/r/err and go to RESP. div_go stays 0.
- RESP (1 cycle): valid of granted client=1. Update last-grant pointer to the granted id. Go to RELEASE.
- RELEASE: stay until div_done=0, then go to IDLE. This prevents a held done from a previous op completing the next one.
- Requests arriving while busy are not queued. They remain pending as level requests and are arbitrated on return to IDLE.
- A req dropped before its ack is never granted. The arbiter does not check y=0; divide-by-zero is reported through div_error.
- q/r/err hold their value until the next RESP capture. They are valid to clients only when valid0 or valid1 is high.
- Reset at any time, including mid-WAIT: next state IDLE and pointer=1. Outputs ack*, valid*, div_go, busy, q, r, err, div_x, div_y all 0; cs=0. div_rst=1 for the reset cycle, aborting the divider.

## Timing
- Request sampled in IDLE at cycle n. ack and div_go asserted at n+1. WAIT begins at n+2.
- div_done seen at cycle m in WAIT: valid at m+1 and q/r/err stable from m+1.
- RELEASE lasts at least 1 cycle. The next grant decision is made no earlier than m+3.
- Back-to-back service of both clients: the second ack follows the first valid by at least 2 cycles.
- All outputs are registered except div_rst, which is combinational from rst OR the abort register.

## Configuration
- DIV_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with div_done still 0, the arbiter forces err=1, q=0, r=0 and goes to RESP. valid is issued normally.
  - div_rst pulses high for exactly 1 cycle, during RESP.
  - If div_done and the limit coincide, div_done wins.
- DIV_ARB_TIMEOUT_EN undefined: no counter. WAIT waits indefinitely, and div_rst equals rst.

## Test plan
- Client 0 only, x0=13, y0=4: ack0 at n+1, then valid0 with q=3, r=1, err=0. valid1 never asserted.
- req0 and req1 both high from the first cycle after reset, x0=9/y0=2 and x1=15/y1=5: client 0 served first (q=4, r=1), then client 1 (q=3, r=0).
- Pointer check: serve client 1 alone (7/7 gives q=1, r=0), then raise both requests: client 0 wins.
- x1=6, y1=0 with the model divider raising div_error: valid1 with err=1.
- Held done: the model holds div_done high for 5 cycles after completion and req1 stays high. cs remains 4 until done falls, and no spurious valid occurs.
- With DIV_ARB_TIMEOUT_EN and TIMEOUT=16, the model never asserts done: valid0 with err=1, q=r=0, and a 1-cycle div_rst pulse. A separate run asserts rst mid-WAIT: next cycle cs=0, busy=0, and no valid is issued.
